// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and AXI constants for the cache read arbiter
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first request at or after ptr
module rr_picker #(
  parameter int N = 2,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] index,
  output logic         any
);

  // scan N positions starting at ptr, wrapping; the first hit wins
  always_comb begin
    int idx;
    grant = '0;
    index = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        index      = W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// rtl/cache_axi_rd_arbiter.sv - round-robin sharing of one AXI read channel among cache requesters
module cache_axi_rd_arbiter
  import cache_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int LINE_WORD_NUM = 4,
  parameter int ID_WIDTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_line,
  input  logic [NUM_REQ*32-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_rdy,
  output logic [NUM_REQ-1:0]    ret_valid,
  output logic [NUM_REQ-1:0]    ret_last,
  output logic [31:0]           ret_data,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic                  err
);

  localparam int         IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORD_NUM - 1);

  arb_state_t        state, state_nx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_q;
  logic [31:0]       addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;
  logic              err_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;
  logic               beat;
  logic               done;
  logic               unused_rid;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_onehot),
    .index (pick_idx),
    .any   (pick_any)
  );

  // R id carries no information here: only one transaction is ever outstanding
  assign unused_rid = ^rid;

  assign accept   = (state == IDLE) && pick_any;
  assign beat     = (state == DATA) && rvalid;
  assign done     = beat && rlast;

  assign arid     = ID_WIDTH'(grant_q);
  assign araddr   = addr_q;
  assign arlen    = len_q;
  assign arsize   = AXI_SIZE_WORD;
  assign arburst  = AXI_BURST_INCR;
  assign ret_data = rdata;
  assign err      = err_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state and handshake outputs; arvalid depends on state only
  always_comb begin
    state_nx  = state;
    req_rdy   = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ret_valid = '0;
    ret_last  = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_rdy  = pick_onehot;
          state_nx = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nx = DATA;
      end
      DATA: begin
        rready             = 1'b1;
        ret_valid[grant_q] = rvalid;
        ret_last[grant_q]  = rvalid & rlast;
        if (rvalid && rlast) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // request latch, beat counter and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        grant_q  <= pick_idx;
        addr_q   <= req_addr[32*int'(pick_idx) +: 32];
        len_q    <= req_line[pick_idx] ? LINE_LEN : 8'd0;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (done) begin
        rr_ptr <= (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IDX_W'(1);
      end
    end
  end

  // sticky error: bad response, early rlast, or a burst running past arlen
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (beat) begin
      if ((rresp != AXI_RESP_OKAY) ||
          (rlast && (beat_cnt != len_q)) ||
          (!rlast && (beat_cnt >= len_q))) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// tb/tb_cache_axi_rd_arbiter.sv - directed self-checking bench for cache_axi_rd_arbiter
module tb_cache_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_line;
  logic [63:0] req_addr;
  logic [1:0]  req_rdy, ret_valid, ret_last;
  logic [31:0] ret_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic        line;
    logic [31:0] addr;
    logic [7:0]  exp_len;
    logic [31:0] base;
  } vec_t;

  vec_t vecs [4];

  cache_axi_rd_arbiter #(.NUM_REQ(2), .LINE_WORD_NUM(4), .ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_line(req_line), .req_addr(req_addr),
    .req_rdy(req_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // AR phase from the first ADDR cycle, with optional arready stall cycles
  task automatic addr_phase(input int idx, input logic [31:0] addr, input logic [7:0] len, input int stall);
    #1;
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, addr);
    check("arlen", arlen, len);
    check("arid", arid, idx);
    check("arsize", arsize, 3'b010);
    check("arburst", arburst, 2'b01);
    check("req_rdy_busy", req_rdy, 2'b00);
    for (int s = 0; s < stall; s++) begin
      tick();
      check("arvalid_stall", arvalid, 1'b1);
      check("araddr_stall", araddr, addr);
      check("arlen_stall", arlen, len);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  // R beats; rlast on the final beat, optional bad rresp and idle gaps between beats
  task automatic data_phase(input int idx, input int nbeats, input logic [31:0] base,
                            input int bad_beat, input int gap);
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          rvalid = 1'b0;
          rlast  = 1'b0;
          #1;
          check("ret_valid_gap", ret_valid, 2'b00);
          check("ret_last_gap", ret_last, 2'b00);
          tick();
        end
      end
      rvalid = 1'b1;
      rdata  = base + 32'(b);
      rlast  = (b == nbeats - 1);
      rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      #1;
      check("rready", rready, 1'b1);
      check("ret_valid", ret_valid, 2'b01 << idx);
      check("ret_data", ret_data, base + 32'(b));
      check("ret_last", ret_last, (b == nbeats - 1) ? (2'b01 << idx) : 2'b00);
      tick();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  // single requester issues a request and is accepted in the current cycle
  task automatic issue(input int idx, input logic line, input logic [31:0] addr);
    req_valid[idx]           = 1'b1;
    req_line[idx]            = line;
    req_addr[idx*32 +: 32]   = addr;
    #1;
    check("req_rdy_accept", req_rdy, 2'b01 << idx);
    check("arvalid_idle", arvalid, 1'b0);
    tick();
    req_valid = 2'b00;
  endtask

  initial begin
    vecs[0] = '{idx: 0, line: 1'b1, addr: 32'h1000_0040, exp_len: 8'd3, base: 32'hD000_0000};
    vecs[1] = '{idx: 1, line: 1'b0, addr: 32'hBFAF_8000, exp_len: 8'd0, base: 32'hCAFE_0000};
    vecs[2] = '{idx: 1, line: 1'b1, addr: 32'h2000_0080, exp_len: 8'd3, base: 32'h1234_5670};
    vecs[3] = '{idx: 0, line: 1'b0, addr: 32'h0000_0004, exp_len: 8'd0, base: 32'h0BAD_F00D};

    rst = 1'b1; req_valid = '0; req_line = '0; req_addr = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_req_rdy", req_rdy, 2'b00);
    check("rst_ret_valid", ret_valid, 2'b00);
    check("rst_ret_last", ret_last, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_arid", arid, 4'd0);

    // table-driven single-requester transactions
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].idx, vecs[i].line, vecs[i].addr);
      addr_phase(vecs[i].idx, vecs[i].addr, vecs[i].exp_len, 0);
      data_phase(vecs[i].idx, int'(vecs[i].exp_len) + 1, vecs[i].base, -1, 0);
      check("err_clean", err, 1'b0);
    end

    // both requesters held: grants alternate 0,1,0,1, back-to-back from the IDLE cycle
    do_reset();
    req_line  = 2'b00;
    req_addr  = {32'hA000_0010, 32'hA000_0000};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_grant", req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_idle_arvalid", arvalid, 1'b0);
      tick();
      addr_phase(k % 2, (k % 2 == 0) ? 32'hA000_0000 : 32'hA000_0010, 8'd0, 0);
      data_phase(k % 2, 1, 32'h5500_0000 + 32'(k), -1, 0);
    end
    req_valid = 2'b00;
    check("rr_err", err, 1'b0);

    // arready stall and rvalid gaps mid-burst
    issue(0, 1'b1, 32'h3000_0100);
    addr_phase(0, 32'h3000_0100, 8'd3, 5);
    data_phase(0, 4, 32'h7700_0000, -1, 2);
    check("stall_err", err, 1'b0);

    // early rlast on the third beat of a len=3 burst
    issue(1, 1'b1, 32'h4000_0040);
    addr_phase(1, 32'h4000_0040, 8'd3, 0);
    data_phase(1, 3, 32'h8800_0000, -1, 0);
    #1;
    check("early_last_err", err, 1'b1);
    check("early_last_idle_arvalid", arvalid, 1'b0);
    check("early_last_idle_rready", rready, 1'b0);
    tick();
    check("err_sticky", err, 1'b1);
    do_reset();
    #1;
    check("err_cleared", err, 1'b0);

    // single word burst overrunning arlen without rlast
    issue(0, 1'b0, 32'h5000_0008);
    addr_phase(0, 32'h5000_0008, 8'd0, 0);
    data_phase(0, 2, 32'h9900_0000, -1, 0);
    #1;
    check("overrun_err", err, 1'b1);
    do_reset();

    // bad rresp on beat 1 still forwards data and sets err
    issue(0, 1'b1, 32'h6000_0000);
    addr_phase(0, 32'h6000_0000, 8'd3, 0);
    data_phase(0, 4, 32'hAA00_0000, 1, 0);
    #1;
    check("rresp_err", err, 1'b1);

    // reset during DATA beat 1 returns to IDLE with everything cleared
    issue(0, 1'b1, 32'h7000_0040);
    addr_phase(0, 32'h7000_0040, 8'd3, 0);
    rvalid = 1'b1; rdata = 32'hBB00_0000; rlast = 1'b0; rresp = 2'b00;
    tick();
    rdata = 32'hBB00_0001;
    rst   = 1'b1;
    tick();
    rst    = 1'b0;
    rvalid = 1'b0;
    #1;
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_ret_valid", ret_valid, 2'b00);
    check("mid_rst_ret_last", ret_last, 2'b00);
    check("mid_rst_req_rdy", req_rdy, 2'b00);
    check("mid_rst_err", err, 1'b0);
    issue(1, 1'b0, 32'hBFAF_8004);
    addr_phase(1, 32'hBFAF_8004, 8'd0, 0);
    data_phase(1, 1, 32'hCC00_0000, -1, 0);
    check("post_rst_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
